// File: rtl/bus3_arb_pkg.sv
// bus3_arb_pkg -- shared constants and types for the 3-requester arbiter.
//
// Contents:
//   NUM_REQ   number of requesters (3)
//   SEL_W     width of the requester select (2)
//   HOLD_W    width of the per-grant hold counter (MAX_HOLD is 1..15)
//   STAT_W    width of the optional per-requester transfer counters
//   state_e   arbiter FSM encoding (IDLE / GRANT)
//   next_idx  round-robin successor of a requester index (wraps 2 -> 0)
package bus3_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int SEL_W   = 2;
    localparam int HOLD_W  = 4;
    localparam int STAT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Successor index modulo NUM_REQ; index 3 is never produced.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return (i >= SEL_W'(NUM_REQ - 1)) ? '0 : i + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3 -- combinational round-robin picker for three requesters.
//
// Ports:
//   req   [2:0]  input   request vector, bit n = requester n pending
//   ptr   [1:0]  input   highest-priority index (search starts here, wraps 2->0)
//   valid        output  at least one request is pending
//   idx   [1:0]  output  first requesting index at or after ptr (0 when !valid)
module rr_pick3
    import bus3_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    int j;

    // Walk the priority order from lowest to highest priority so the last
    // hit (the one closest to ptr) wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                idx = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus3_arbiter.sv
// bus3_arbiter -- round-robin arbiter steering three requesters onto one
// registered output word with a valid/ready handshake.
//
// Parameters:
//   DATA_W    requester / output data width
//   MAX_HOLD  max consecutive transfers per grant (1..15)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0..req2            requester n has a word pending
//   d0..d2     [DATA_W]   requester n data (stable while reqn && !ackn)
//   ack0..ack2            one-cycle pulse: requester n's word was accepted
//   sel        [1:0]      registered grant index (0..2) for the datapath mux
//   m          [DATA_W]   registered output word
//   m_valid               m holds an unaccepted word
//   m_ready               downstream accepts m this cycle
//   gnt_cnt0..2 [16]      transfers per requester, wrapping
//                         (only with BUS3_ARB_STATS_EN defined)
//
// Build option: define BUS3_ARB_STATS_EN to add the gnt_cnt* counters.
module bus3_arbiter
    import bus3_arb_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              req2,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    output logic              ack0,
    output logic              ack1,
    output logic              ack2,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] m,
    output logic              m_valid,
    input  logic              m_ready
`ifdef BUS3_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] gnt_cnt0,
    output logic [STAT_W-1:0] gnt_cnt1,
    output logic [STAT_W-1:0] gnt_cnt2
`endif
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q,   ptr_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [DATA_W-1:0]   m_q,     m_d;
    logic                mv_q,    mv_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;
    logic [NUM_REQ-1:0]  ack_q,   ack_d;

    logic [NUM_REQ-1:0]  req_v;
    logic [SEL_W-1:0]    pick_ptr;
    logic                pick_valid;
    logic [SEL_W-1:0]    pick_idx;
    logic [DATA_W-1:0]   pick_data;
    logic [DATA_W-1:0]   cur_data;
    logic                xfer;

    assign req_v = {req2, req1, req0};
    assign xfer  = mv_q & m_ready;

    // While granted, the picker only matters when the grant ends, and then
    // the search starts just past the current owner. From IDLE it starts at
    // the stored pointer. One picker serves both cases.
    assign pick_ptr = (state_q == GRANT) ? next_idx(sel_q) : ptr_q;

    rr_pick3 u_pick (
        .req   (req_v),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // 3:1 data muxes: one for a fresh grant, one for a hold reload.
    always_comb begin
        pick_data = d0;
        case (pick_idx)
            2'd1:    pick_data = d1;
            2'd2:    pick_data = d2;
            default: pick_data = d0;
        endcase
    end

    always_comb begin
        cur_data = d0;
        case (sel_q)
            2'd1:    cur_data = d1;
            2'd2:    cur_data = d2;
            default: cur_data = d0;
        endcase
    end

    // Next-state / output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        m_d     = m_q;
        mv_d    = mv_q;
        hold_d  = hold_q;
        ack_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    m_d     = pick_data;
                    mv_d    = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = GRANT;
                end
            end

            GRANT: begin
                // Without a transfer everything holds: a committed word is
                // never retracted, whatever the requesters do.
                if (xfer) begin
                    ack_d = NUM_REQ'(1) << sel_q;
                    if (req_v[sel_q] && (hold_q < HOLD_W'(MAX_HOLD))) begin
                        m_d    = cur_data;
                        hold_d = hold_q + HOLD_W'(1);
                    end else begin
                        ptr_d = next_idx(sel_q);
                        if (pick_valid) begin
                            sel_d  = pick_idx;
                            m_d    = pick_data;
                            hold_d = HOLD_W'(1);
                        end else begin
                            mv_d    = 1'b0;
                            hold_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                mv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            m_q     <= '0;
            mv_q    <= 1'b0;
            hold_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            m_q     <= m_d;
            mv_q    <= mv_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
        end
    end

    assign sel     = sel_q;
    assign m       = m_q;
    assign m_valid = mv_q;
    assign ack0    = ack_q[0];
    assign ack1    = ack_q[1];
    assign ack2    = ack_q[2];

`ifdef BUS3_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] cnt_q;

    // Counts accepted words per requester; wraps naturally at 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + STAT_W'(1);
        end
    end

    assign gnt_cnt0 = cnt_q[0];
    assign gnt_cnt1 = cnt_q[1];
    assign gnt_cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_bus3_arbiter.sv
// tb_bus3_arbiter -- scoreboard bench for bus3_arbiter.
// Two instances share stimulus: inst 0 with MAX_HOLD=4, inst 1 with MAX_HOLD=1.
// A transfer-level reference model pushes each word it expects the arbiter to
// commit into a per-instance queue; a negedge monitor compares and pops.
module tb_bus3_arbiter;

    localparam int DW = 16;
    localparam int NI = 2;

    function automatic int mh(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    logic          clk;
    logic          rst_n;
    logic          req0, req1, req2;
    logic [DW-1:0] d0, d1, d2;
    logic          m_ready;

    logic [NI-1:0][2:0]    ack_w;
    logic [NI-1:0][1:0]    sel_w;
    logic [NI-1:0][DW-1:0] m_w;
    logic [NI-1:0]         mv_w;
`ifdef BUS3_ARB_STATS_EN
    logic [NI-1:0][2:0][15:0] gc_w;
`endif

    int errors = 0;
    int checks = 0;

    bus3_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .d0(d0), .d1(d1), .d2(d2),
        .ack0(ack_w[0][0]), .ack1(ack_w[0][1]), .ack2(ack_w[0][2]),
        .sel(sel_w[0]), .m(m_w[0]), .m_valid(mv_w[0]), .m_ready(m_ready)
`ifdef BUS3_ARB_STATS_EN
        , .gnt_cnt0(gc_w[0][0]), .gnt_cnt1(gc_w[0][1]), .gnt_cnt2(gc_w[0][2])
`endif
    );

    bus3_arbiter #(.DATA_W(DW), .MAX_HOLD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .req2(req2),
        .d0(d0), .d1(d1), .d2(d2),
        .ack0(ack_w[1][0]), .ack1(ack_w[1][1]), .ack2(ack_w[1][2]),
        .sel(sel_w[1]), .m(m_w[1]), .m_valid(mv_w[1]), .m_ready(m_ready)
`ifdef BUS3_ARB_STATS_EN
        , .gnt_cnt0(gc_w[1][0]), .gnt_cnt1(gc_w[1][1]), .gnt_cnt2(gc_w[1][2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%0d exp=%0d t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            mv  [NI];   // a word is committed and not yet accepted
    int            ms  [NI];   // owner of the committed word
    int            hc  [NI];   // words taken in the current grant
    int            mp  [NI];   // round-robin start index
    int            cnt [NI][3];
    logic [17:0]   sbq [NI][$];
    logic [DW-1:0] dv  [3];
    logic [2:0]    rq;
    int            g, hn;

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                mv[i] = 0; ms[i] = 0; hc[i] = 0; mp[i] = 0;
                sbq[i].delete();
                for (int r = 0; r < 3; r++) cnt[i][r] = 0;
            end
        end else begin
            rq = {req2, req1, req0};
            dv[0] = d0; dv[1] = d1; dv[2] = d2;
            for (int i = 0; i < NI; i++) begin
                g  = -1;
                hn = 1;
                if (mv[i] == 0) begin
                    g = pick(rq, mp[i]);
                end else if (m_ready) begin
                    cnt[i][ms[i]] = (cnt[i][ms[i]] + 1) % 65536;
                    if (rq[ms[i]] && hc[i] < mh(i)) begin
                        g  = ms[i];
                        hn = hc[i] + 1;
                    end else begin
                        mp[i] = (ms[i] + 1) % 3;
                        mv[i] = 0;
                        g     = pick(rq, mp[i]);
                    end
                end
                if (g >= 0) begin
                    mv[i] = 1;
                    ms[i] = g;
                    hc[i] = hn;
                    sbq[i].push_back({2'(g), dv[g]});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [2:0]  ack_pend [NI];
    logic [17:0] e;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                ack_pend[i] = '0;
            end else begin
                chk("ack", i, 32'(ack_w[i]), 32'(ack_pend[i]));
                chk("m_valid", i, 32'(mv_w[i]), 32'(mv[i]));
                ack_pend[i] = '0;
                if (mv[i] != 0) begin
                    if (sbq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty[%0d] got=none exp=word t=%0t", i, $time);
                    end else begin
                        e = sbq[i][0];
                        chk("sel", i, 32'(sel_w[i]), 32'(e[17:16]));
                        chk("m", i, 32'(m_w[i]), 32'(e[15:0]));
                        if (m_ready) begin
                            ack_pend[i] = 3'b001 << e[17:16];
                            void'(sbq[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_sel", i, 32'(sel_w[i]), 0);
            chk("rst_m", i, 32'(m_w[i]), 0);
            chk("rst_mv", i, 32'(mv_w[i]), 0);
            chk("rst_ack", i, 32'(ack_w[i]), 0);
        end
        tick(2);
        {req2, req1, req0} = 3'b000;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {req2, req1, req0} = 3'b000;
        d0 = 16'd10; d1 = 16'd22; d2 = 16'd764;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single requester: one-cycle latency, ack the cycle after transfer.
        req0 = 1'b1; m_ready = 1'b1;
        tick(1);
        for (int i = 0; i < NI; i++) begin
            chk("lat_mv", i, 32'(mv_w[i]), 1);
            chk("lat_m", i, 32'(m_w[i]), 10);
            chk("lat_sel", i, 32'(sel_w[i]), 0);
        end
        req0 = 1'b0;
        tick(1);
        for (int i = 0; i < NI; i++) begin
            chk("ack0_pulse", i, 32'(ack_w[i]), 1);
            chk("drain_mv", i, 32'(mv_w[i]), 0);
        end
        tick(2);

        // All requesting, always ready: exactly six transfers.
        do_reset();
        {req2, req1, req0} = 3'b111; m_ready = 1'b1;
        tick(7);
        m_ready = 1'b0;
`ifdef BUS3_ARB_STATS_EN
        for (int r = 0; r < 3; r++) chk("gnt_cnt_rr", r, 32'(gc_w[1][r]), 2);
`endif
        {req2, req1, req0} = 3'b000; m_ready = 1'b1;
        tick(8);

        // Hold limit: requester 1 first, then requester 0 joins.
        do_reset();
        req1 = 1'b1; m_ready = 1'b1;
        tick(1);
        req0 = 1'b1;
        tick(12);
        {req2, req1, req0} = 3'b000;
        tick(6);

        // Backpressure with wandering requests.
        {req2, req1, req0} = 3'b111; m_ready = 1'b1;
        tick(2);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            {req2, req1, req0} = 3'($urandom_range(0, 7));
            tick(1);
        end
        m_ready = 1'b1; {req2, req1, req0} = 3'b111;
        tick(3);

        // Reset in the middle of a burst.
        #2;
        do_reset();
        req2 = 1'b1;
        tick(1);
        for (int i = 0; i < NI; i++) begin
            chk("post_rst_sel", i, 32'(sel_w[i]), 2);
            chk("post_rst_m", i, 32'(m_w[i]), 764);
        end
        req2 = 1'b0;
        tick(3);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            {req2, req1, req0} = 3'($urandom_range(0, 7));
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) d0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d2 = 16'($urandom);
            tick(1);
        end
        {req2, req1, req0} = 3'b000; m_ready = 1'b1;
        tick(6);

`ifdef BUS3_ARB_STATS_EN
        for (int i = 0; i < NI; i++)
            for (int r = 0; r < 3; r++)
                chk("gnt_cnt", i * 3 + r, 32'(gc_w[i][r]), 32'(cnt[i][r]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus3_arbiter.md
BUS3_ARBITER -- requirements
Module: bus3_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the requester and output data width.
REQ-002 SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive transfers one requester may make per grant (1..15).
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1/req2, input, 1 each, requester n has data pending.
REQ-006 SHALL have ports d0/d1/d2, input, DATA_W each, requester n data; held stable while reqn=1 and ackn=0.
REQ-007 SHALL have ports ack0/ack1/ack2, output, 1 each, one-cycle pulse: requester n's current word was accepted downstream.
REQ-008 SHALL have port sel, output, 2, registered select of the granted requester (0..2) for the shared 3:1 datapath mux.
REQ-009 SHALL have port m, output, DATA_W, registered output word.
REQ-010 SHALL have port m_valid, output, 1, m holds an unaccepted word.
REQ-011 SHALL have port m_ready, input, 1, downstream accepts m this cycle.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT.
REQ-013 IDLE: on any reqn=1, SHALL pick the first requesting index at or after round-robin pointer ptr (wrapping 2->0), load sel, m=d[sel], m_valid=1, hold count=1, enter GRANT at the next edge (latency 1 cycle req->m_valid).
REQ-014 Transfer occurs on a cycle with m_valid=1 and m_ready=1; SHALL pulse ack[sel] in the following cycle only.
REQ-015 After a transfer, if req[sel] remains 1 and hold count < MAX_HOLD, SHALL reload m=d[sel], increment hold count, keep m_valid=1 (back-to-back, one word per cycle).
REQ-016 After a transfer with hold count = MAX_HOLD, or req[sel]=0, SHALL set ptr=sel+1 mod 3 and re-arbitrate in the same cycle as from IDLE; if no requester, SHALL clear m_valid and enter IDLE.
REQ-017 While m_valid=1 and m_ready=0, m, sel and m_valid SHALL hold unchanged, regardless of req changes.
REQ-018 A requester dropping reqn while granted and unaccepted SHALL NOT retract m (already committed).
REQ-019 sel SHALL never take value 3.
REQ-020 Simultaneous req0/req1/req2 from IDLE with ptr=0 SHALL grant 0, then 1, then 2.

Reset
REQ-021 On rst_n=0, asynchronously: state=IDLE, ptr=0, sel=0, m=0, m_valid=0, ack0..2=0, hold count=0.
REQ-022 Reset mid-transfer SHALL drop the pending word with no ack; first grant after release follows REQ-013 with ptr=0.

Configuration
REQ-023 Macro BUS3_ARB_STATS_EN, when defined, SHALL add outputs gnt_cnt0/1/2 (16 bits each, wrap at 65535->0) counting transfers per requester, cleared by reset.
REQ-024 Without BUS3_ARB_STATS_EN, the counters and ports SHALL be absent; all other behaviour identical.

Structure
REQ-025 SHALL place state encoding (IDLE/GRANT), the requester-count constant 3 and the select width 2 in the shared package bus3_arb_pkg.
REQ-026 SHALL put round-robin next-index selection in sub-module rr_pick3 (inputs req[2:0], ptr; outputs valid, idx).
REQ-027 SHALL keep data steering in the existing 3:1 mux style (sel-indexed), registered once at m.

Verification
REQ-028 d0=10, req0 only, m_ready=1 -> m=10, sel=0, m_valid one cycle after req0, ack0 pulse next cycle.
REQ-029 d0=10,d1=22,d2=764, all req held, m_ready=1, MAX_HOLD=1 -> m sequence 10,22,764,10..., sel 0,1,2,0.
REQ-030 req1 held continuously, MAX_HOLD=4, req0 also asserted -> four words from 1, then grant to 0 (sel 1,1,1,1,2?no req2 ->0).
REQ-031 m_valid=1, m_ready=0 for 5 cycles, req changes -> m, sel stable, no ack; ack after m_ready rises.
REQ-032 rst_n low mid-burst -> all outputs 0 immediately, no ack; after release req2 alone -> sel=2, m=764.
REQ-033 BUS3_ARB_STATS_EN defined, scenario REQ-029 for 6 transfers -> gnt_cnt0/1/2 = 2/2/2.
